// File: rtl/ram_port_arbiter_if.sv
// Single-beat request/grant bus between one RAM master and the port-A arbiter.
// Read data comes back on rvalid/rdata a fixed number of cycles after the grant.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Port-A arbiter for the video/data RAM: burst-limited round-robin between the CPU (m0)
// and the auxiliary engine (m1), with in-order read return after the fixed RAM latency.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  ram_port_arbiter_if.slave  m0,
  ram_port_arbiter_if.slave  m1,
  output logic [ADDR_W-1:0]  ram_address,
  output logic [DATA_W-1:0]  ram_data,
  output logic               ram_wren,
  input  logic [DATA_W-1:0]  ram_q,
  output logic [1:0]         owner
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OWN0 = 2'b01;
  localparam logic [1:0] OWN1 = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gnt0, gnt1;
  logic             acc0, acc1;
  logic             rd_issue;
  logic [RD_LAT:0]  rd_vld_p;
  logic [RD_LAT:0]  rd_id_p;
  logic             rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata_hold0, rdata_hold1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  // Grant decision: the current owner keeps the port until the other master has waited
  // out a full burst; a handover grants the new owner in the same cycle.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      OWN0: begin
        if (m0.req && (!m1.req || cnt < CNT_MAX)) begin
          gnt0    = 1'b1;
          cnt_nxt = sat_inc(cnt);
        end else if (m1.req) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      OWN1: begin
        if (m1.req && (!m0.req || cnt < CNT_MAX)) begin
          gnt1    = 1'b1;
          cnt_nxt = sat_inc(cnt);
        end else if (m0.req) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (m0.req) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          cnt_nxt   = CNT_ONE;
        end else if (m1.req) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    endcase
    // No beat may be accepted while reset is held, even with requests pending.
    if (!reset_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;
  assign acc0   = m0.req & gnt0;
  assign acc1   = m1.req & gnt1;
  assign owner  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p0: accepted beat registered onto RAM port A
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else if (acc0) begin
      ram_address <= m0.addr;
      ram_data    <= m0.wdata;
      ram_wren    <= m0.we;
    end else if (acc1) begin
      ram_address <= m1.addr;
      ram_data    <= m1.wdata;
      ram_wren    <= m1.we;
    end else begin
      ram_wren    <= 1'b0;
    end
  end

  // Stages p0..pRD_LAT: read tag (valid, issuer) travels alongside the RAM access
  assign rd_issue = (acc0 & ~m0.we) | (acc1 & ~m1.we);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_p <= '0;
      rd_id_p  <= '0;
    end else begin
      rd_vld_p <= {rd_vld_p[RD_LAT-1:0], rd_issue};
      rd_id_p  <= {rd_id_p[RD_LAT-1:0], acc1};
    end
  end

  assign rvalid0 = rd_vld_p[RD_LAT] & ~rd_id_p[RD_LAT];
  assign rvalid1 = rd_vld_p[RD_LAT] &  rd_id_p[RD_LAT];

  // Return stage: rdata follows ram_q during the pulse and then holds for that master
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_hold0 <= '0;
      rdata_hold1 <= '0;
    end else begin
      if (rvalid0) rdata_hold0 <= ram_q;
      if (rvalid1) rdata_hold1 <= ram_q;
    end
  end

  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rvalid0 ? ram_q : rdata_hold0;
  assign m1.rdata  = rvalid1 ? ram_q : rdata_hold1;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural port-A RAM and a read-return
// scoreboard fed by observed read accepts and drained by a separate return monitor.
module tb_ram_port_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [1:0]        owner;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clk), .reset_n(rst_n), .m0(m0_if), .m1(m1_if),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .owner(owner)
  );

  // Port-A RAM: address sampled one clock after the beat, q valid RD_LAT clocks later
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    rd_pipe[0] <= mem[ram_address];
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_q = rd_pipe[RD_LAT-1];

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic              id;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;
  exp_t sb[$];

  logic [DATA_W-1:0] m0_exp = '0;
  logic [DATA_W-1:0] m1_exp = '0;

  // Accept observer: every read beat accepted enqueues its hand-computed return
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_if.req && m0_if.gnt && !m0_if.we) sb.push_back('{1'b0, m0_exp, cyc + 1 + RD_LAT});
      if (m1_if.req && m1_if.gnt && !m1_if.we) sb.push_back('{1'b1, m1_exp, cyc + 1 + RD_LAT});
    end
  end

  // Return monitor
  logic [DATA_W-1:0] last_r0 = '0;
  logic [DATA_W-1:0] last_r1 = '0;
  always @(negedge clk) begin
    exp_t e;
    if (m0_if.rvalid || m1_if.rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rvalid_issuer", {30'd0, m1_if.rvalid, m0_if.rvalid}, e.id ? 32'd2 : 32'd1);
        check("rvalid_cycle", cyc, e.due);
        if (e.id) begin
          check("m1_rdata", {16'd0, m1_if.rdata}, {16'd0, e.data});
          check("m0_rdata_hold", {16'd0, m0_if.rdata}, {16'd0, last_r0});
        end else begin
          check("m0_rdata", {16'd0, m0_if.rdata}, {16'd0, e.data});
          check("m1_rdata_hold", {16'd0, m1_if.rdata}, {16'd0, last_r1});
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("rvalid_missing", {30'd0, m1_if.rvalid, m0_if.rvalid}, e.id ? 32'd2 : 32'd1);
    end
    last_r0 = m0_if.rdata;
    last_r1 = m1_if.rdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
    $fatal(1);
  end

  task automatic drive(input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic [15:0] e0, input logic r1, input logic w1, input logic [15:0] a1,
                       input logic [15:0] d1, input logic [15:0] e1);
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0; m0_exp = e0;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1; m1_exp = e1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gnts();
    return {30'd0, m1_if.gnt, m0_if.gnt};
  endfunction

  initial begin
    // Reset held with both masters requesting (writes that preload the RAM)
    drive(1'b1, 1'b1, 16'h0001, 16'h1111, 16'h0, 1'b1, 1'b1, 16'h0002, 16'h2222, 16'h0);
    settle();
    check("rst_gnt", gnts(), 32'd0);
    check("rst_wren", {31'd0, ram_wren}, 32'd0);
    check("rst_addr", {16'd0, ram_address}, 32'd0);
    check("rst_data", {16'd0, ram_data}, 32'd0);
    check("rst_owner", {30'd0, owner}, 32'd0);
    check("rst_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    check("rst_rdata", {m1_if.rdata, m0_if.rdata}, 32'd0);
    next(); next();
    rst_n = 1'b1;
    settle();
    check("rel_gnt", gnts(), 32'd1);
    next();
    m0_if.req = 1'b0;
    settle();
    check("rel_owner", {30'd0, owner}, 32'd1);
    check("handover_gnt", gnts(), 32'd2);
    check("beat0_wren", {31'd0, ram_wren}, 32'd1);
    check("beat0_addr", {16'd0, ram_address}, 32'h0001);
    check("beat0_data", {16'd0, ram_data}, 32'h1111);
    next();
    idle();
    settle();
    check("own1_owner", {30'd0, owner}, 32'd2);
    check("beat1_addr", {16'd0, ram_address}, 32'h0002);
    check("beat1_data", {16'd0, ram_data}, 32'h2222);
    next();
    settle();
    check("idle_owner", {30'd0, owner}, 32'd0);
    check("idle_wren", {31'd0, ram_wren}, 32'd0);
    check("idle_addr_hold", {16'd0, ram_address}, 32'h0002);
    next();

    // Write then read-after-write on m0
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    check("raw_wr_gnt", gnts(), 32'd1);
    next();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    settle();
    check("raw_rd_gnt", gnts(), 32'd1);
    check("raw_wren", {31'd0, ram_wren}, 32'd1);
    check("raw_addr", {16'd0, ram_address}, 32'h0010);
    check("raw_data", {16'd0, ram_data}, 32'hBEEF);
    next();
    idle();
    settle();
    check("raw_rd_wren", {31'd0, ram_wren}, 32'd0);
    next();
    for (int i = 0; i < RD_LAT + 3; i++) begin settle(); next(); end

    // Both masters requesting continuously: 8 beats each, alternating
    drive(1'b1, 1'b1, 16'h0100, 16'hA000, 16'h0, 1'b1, 1'b1, 16'h0200, 16'hB000, 16'h0);
    for (int k = 0; k < 34; k++) begin
      settle();
      check("burst_gnt", gnts(), ((k / MAX_BURST) % 2 == 0) ? 32'd1 : 32'd2);
      next();
    end
    idle();
    settle(); next();

    // Alternating reads m0@0x0001 / m1@0x0002
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b0, 16'h0001, 16'h0, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      else            drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0, 16'h2222);
      settle();
      check("alt_gnt", gnts(), (i % 2 == 0) ? 32'd1 : 32'd2);
      next();
    end
    idle();
    for (int i = 0; i < RD_LAT + 3; i++) begin settle(); next(); end

    // Three reads in flight, then a one-cycle reset pulse drops them all
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("flush_rd_gnt", gnts(), 32'd1);
      next();
    end
    idle();
    rst_n = 1'b0;
    sb.delete();
    settle();
    check("pulse_owner", {30'd0, owner}, 32'd0);
    check("pulse_rvalid", {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    check("pulse_wren", {31'd0, ram_wren}, 32'd0);
    next();
    rst_n = 1'b1;
    for (int i = 0; i < RD_LAT + 3; i++) begin
      settle();
      check("post_pulse_owner", {30'd0, owner}, 32'd0);
      next();
    end

    // m1 alone gets the port at once; m0 joins at beat 3 and waits out the burst
    for (int k = 0; k < 9; k++) begin
      drive(k >= 3, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b1, 1'b1, 16'h0300, 16'hC000 + 16'(k), 16'h0);
      settle();
      check("m1_burst_gnt", gnts(), (k < MAX_BURST) ? 32'd2 : 32'd1);
      if (k == 1) begin
        check("m1_beat_wren", {31'd0, ram_wren}, 32'd1);
        check("m1_beat_data", {16'd0, ram_data}, 32'hC000);
      end
      next();
    end
    idle();
    for (int i = 0; i < RD_LAT + 4; i++) begin settle(); next(); end
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
